// File: rtl/tcm_boot_loader.sv
// Streams a byte image into TCM as little-endian words and holds the core in reset until done.
// Optional TCM_BOOT_LOADER_CHECKSUM_EN adds a running sum of written words on checksum_o.
module tcm_boot_loader #(
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int unsigned MAX_BYTES     = 131072,
    parameter int unsigned RELEASE_DELAY = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_last_i,
    output logic        byte_ready_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_wr_o,
    output logic [3:0]  mem_wr_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic        mem_error_i,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] bytes_loaded_o,
    output logic [31:0] checksum_o
);

    typedef enum logic [2:0] {
        StIdle, StCollect, StWrite, StWaitAck, StRelease, StDone, StError
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_data, w_data_nxt;
    logic [31:0] r_count, w_count_nxt;
    logic [3:0]  r_strb, w_strb_nxt;
    logic        r_last, w_last_nxt;
    logic [7:0]  r_rel_cnt, w_rel_cnt_nxt;
    logic        w_start, w_byte_fire, w_ack, w_ack_ok;
    logic [1:0]  w_lane;

    assign w_start     = start_i && (r_state inside {StIdle, StDone, StError});
    assign w_byte_fire = (r_state == StCollect) && byte_valid_i;
    assign w_lane      = r_count[1:0];
    // Ack may arrive in the same cycle as accept, bypassing the WAIT_ACK cycle.
    assign w_ack       = mem_ack_i &&
                         ((r_state == StWaitAck) || ((r_state == StWrite) && mem_accept_i));
    assign w_ack_ok    = w_ack && !mem_error_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_addr    <= BASE_ADDR;
            r_data    <= '0;
            r_count   <= '0;
            r_strb    <= '0;
            r_last    <= 1'b0;
            r_rel_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_count   <= w_count_nxt;
            r_strb    <= w_strb_nxt;
            r_last    <= w_last_nxt;
            r_rel_cnt <= w_rel_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_data_nxt    = r_data;
        w_count_nxt   = r_count;
        w_strb_nxt    = r_strb;
        w_last_nxt    = r_last;
        w_rel_cnt_nxt = r_rel_cnt;
        case (r_state)
            StIdle, StDone, StError: begin
                if (w_start) begin
                    w_count_nxt = '0;
                    w_addr_nxt  = BASE_ADDR;
                    w_data_nxt  = '0;
                    w_strb_nxt  = '0;
                    w_last_nxt  = 1'b0;
                    w_state_nxt = StCollect;
                end
            end
            StCollect: begin
                if (w_byte_fire) begin
                    if (r_count == 32'(MAX_BYTES)) begin
                        w_state_nxt = StError;
                    end else begin
                        w_data_nxt[{w_lane, 3'b000} +: 8] = byte_data_i;
                        w_strb_nxt[w_lane] = 1'b1;
                        w_count_nxt = r_count + 32'd1;
                        w_last_nxt  = byte_last_i;
                        if (w_lane == 2'd3 || byte_last_i) begin
                            w_state_nxt = StWrite;
                        end
                    end
                end
            end
            StWrite: begin
                if (mem_accept_i && !mem_ack_i) begin
                    w_state_nxt = StWaitAck;
                end
            end
            StRelease: begin
                w_rel_cnt_nxt = r_rel_cnt - 8'd1;
                if (r_rel_cnt <= 8'd1) begin
                    w_state_nxt = StDone;
                end
            end
            default: ;
        endcase

        if (w_ack_ok) begin
            w_addr_nxt    = r_addr + 32'd4;
            w_data_nxt    = '0;
            w_strb_nxt    = '0;
            w_rel_cnt_nxt = 8'(RELEASE_DELAY);
            w_state_nxt   = r_last ? StRelease : StCollect;
        end else if (w_ack) begin
            w_state_nxt = StError;
        end
    end

    assign byte_ready_o   = (r_state == StCollect);
    assign mem_addr_o     = r_addr;
    assign mem_data_wr_o  = r_data;
    assign mem_wr_o       = (r_state == StWrite) ? r_strb : 4'h0;
    assign core_rst_o     = (r_state != StDone);
    assign busy_o         = r_state inside {StCollect, StWrite, StWaitAck, StRelease};
    assign done_o         = (r_state == StDone);
    assign error_o        = (r_state == StError);
    assign bytes_loaded_o = r_count;

`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (w_ack_ok) begin
            r_checksum <= r_checksum + r_data;
        end
    end

    assign checksum_o = r_checksum;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_tcm_boot_loader.sv
// Directed bench for tcm_boot_loader; a second instance with MAX_BYTES=4 covers the size limit.
module tb_tcm_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_last = 1'b0;
    logic        mem_accept = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_error = 1'b0;

    logic        byte_ready_o, core_rst_o, busy_o, done_o, error_o;
    logic [31:0] mem_addr_o, mem_data_wr_o, bytes_loaded_o, checksum_o;
    logic [3:0]  mem_wr_o;

    logic        m_byte_ready_o, m_core_rst_o, m_busy_o, m_done_o, m_error_o;
    logic [31:0] m_mem_addr_o, m_mem_data_wr_o, m_bytes_loaded_o, m_checksum_o;
    logic [3:0]  m_mem_wr_o;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    tcm_boot_loader dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_last_i(byte_last),
        .byte_ready_o(byte_ready_o), .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o),
        .mem_wr_o(mem_wr_o), .mem_accept_i(mem_accept), .mem_ack_i(mem_ack),
        .mem_error_i(mem_error), .core_rst_o(core_rst_o), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .bytes_loaded_o(bytes_loaded_o), .checksum_o(checksum_o)
    );

    tcm_boot_loader #(.MAX_BYTES(4)) dut_m (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_last_i(byte_last),
        .byte_ready_o(m_byte_ready_o), .mem_addr_o(m_mem_addr_o),
        .mem_data_wr_o(m_mem_data_wr_o), .mem_wr_o(m_mem_wr_o), .mem_accept_i(mem_accept),
        .mem_ack_i(mem_ack), .mem_error_i(mem_error), .core_rst_o(m_core_rst_o),
        .busy_o(m_busy_o), .done_o(m_done_o), .error_o(m_error_o),
        .bytes_loaded_o(m_bytes_loaded_o), .checksum_o(m_checksum_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
        mem_accept = 1'b0; mem_ack = 1'b0; mem_error = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n;
        byte_valid = 1'b1; byte_data = d; byte_last = last; n = 0;
        while (!byte_ready_o && n < 50) begin
            tick(); n++;
        end
        if (n >= 50) begin
            n_total++;
            $display("FAIL send_byte_timeout: byte_ready_o=%0b required 1", byte_ready_o);
        end
        tick();
        byte_valid = 1'b0; byte_last = 1'b0;
    endtask

    task automatic wait_write(output logic [31:0] a, output logic [31:0] d, output logic [3:0] s);
        int n;
        n = 0;
        while (mem_wr_o == 4'h0 && n < 50) begin
            tick(); n++;
        end
        if (n >= 50) begin
            n_total++;
            $display("FAIL write_timeout: mem_wr_o=%h required non-zero", mem_wr_o);
        end
        a = mem_addr_o; d = mem_data_wr_o; s = mem_wr_o;
    endtask

    task automatic mem_respond(input bit same, input bit err);
        mem_accept = 1'b1; mem_ack = same; mem_error = same & err;
        tick();
        mem_accept = 1'b0;
        if (!same) begin
            mem_ack = 1'b1; mem_error = err;
            tick();
        end
        mem_ack = 1'b0; mem_error = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_o && !error_o && n < 50) begin
            tick(); n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({byte_ready_o, mem_wr_o, core_rst_o, busy_o, done_o, error_o} !== 9'b0_0000_1000)
            $display("FAIL reset_ctrl: got %b required 000001000",
                     {byte_ready_o, mem_wr_o, core_rst_o, busy_o, done_o, error_o});
        else n_pass++;
        n_total++;
        if ({mem_addr_o, mem_data_wr_o, bytes_loaded_o} !== {32'h8000_0000, 64'h0})
            $display("FAIL reset_data: addr=%h data=%h bytes=%0d required 80000000/0/0",
                     mem_addr_o, mem_data_wr_o, bytes_loaded_o);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] a, d;
        logic [3:0]  s;
        logic [31:0] exp_sum;
        int n;
        do_reset();
        pulse_start();
        n_total++;
        if ({busy_o, byte_ready_o, core_rst_o} !== 3'b111)
            $display("FAIL start_collect: busy/ready/rst=%b required 111",
                     {busy_o, byte_ready_o, core_rst_o});
        else n_pass++;
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        wait_write(a, d, s);
        n_total++;
        if ({a, d, s} !== {32'h8000_0000, 32'h0403_0201, 4'hF})
            $display("FAIL basic_w0: addr=%h data=%h strb=%h required 80000000 04030201 f",
                     a, d, s);
        else n_pass++;
        n_total++;
        if (byte_ready_o !== 1'b0)
            $display("FAIL ready_in_write: byte_ready_o=%0b required 0", byte_ready_o);
        else n_pass++;
        mem_respond(1'b0, 1'b0);
        for (int i = 5; i <= 8; i++) send_byte(8'(i), i == 8);
        wait_write(a, d, s);
        n_total++;
        if ({a, d, s} !== {32'h8000_0004, 32'h0807_0605, 4'hF})
            $display("FAIL basic_w1: addr=%h data=%h strb=%h required 80000004 08070605 f",
                     a, d, s);
        else n_pass++;
        mem_respond(1'b1, 1'b0);
        n = 0;
        while (core_rst_o && n < 20) begin
            tick(); n++;
        end
        n_total++;
        if (n !== 5) $display("FAIL release_delay: cycles=%0d required 5", n);
        else n_pass++;
        n_total++;
        if ({done_o, busy_o, error_o, bytes_loaded_o} !== {3'b100, 32'd8})
            $display("FAIL basic_done: done/busy/err=%b bytes=%0d required 100 8",
                     {done_o, busy_o, error_o}, bytes_loaded_o);
        else n_pass++;
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
        exp_sum = 32'h0C0A_0806;
`else
        exp_sum = 32'h0;
`endif
        n_total++;
        if (checksum_o !== exp_sum)
            $display("FAIL basic_checksum: got %h required %h", checksum_o, exp_sum);
        else n_pass++;
    endtask

    task automatic test_tail();
        logic [31:0] a, d;
        logic [3:0]  s;
        do_reset();
        pulse_start();
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
        wait_write(a, d, s);
        n_total++;
        if (d !== 32'hDDCC_BBAA) $display("FAIL tail_w0: data=%h required ddccbbaa", d);
        else n_pass++;
        mem_respond(1'b1, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b1);
        wait_write(a, d, s);
        n_total++;
        if ({a, d, s} !== {32'h8000_0004, 32'h0000_2211, 4'h3})
            $display("FAIL tail_w1: addr=%h data=%h strb=%h required 80000004 00002211 3",
                     a, d, s);
        else n_pass++;
        mem_respond(1'b1, 1'b0);
        wait_done();
        n_total++;
        if ({done_o, core_rst_o, bytes_loaded_o} !== {2'b10, 32'd6})
            $display("FAIL tail_done: done/rst=%b bytes=%0d required 10 6",
                     {done_o, core_rst_o}, bytes_loaded_o);
        else n_pass++;
    endtask

    task automatic test_hold();
        logic [31:0] a, d;
        logic [3:0]  s;
        int bad;
        do_reset();
        pulse_start();
        for (int i = 1; i <= 4; i++) send_byte(8'(8'h40 + i), 1'b0);
        wait_write(a, d, s);
        byte_valid = 1'b1; byte_data = 8'h55; byte_last = 1'b1;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if ({mem_addr_o, mem_data_wr_o, mem_wr_o, byte_ready_o} !== {a, d, s, 1'b0})
                bad++;
        end
        n_total++;
        if (bad !== 0 || d !== 32'h4443_4241)
            $display("FAIL hold_stable: unstable_cycles=%0d data=%h required 0 44434241",
                     bad, d);
        else n_pass++;
        mem_respond(1'b1, 1'b0);
        tick();
        byte_valid = 1'b0; byte_last = 1'b0;
        wait_write(a, d, s);
        n_total++;
        if ({a, d, s, bytes_loaded_o} !== {32'h8000_0004, 32'h0000_0055, 4'h1, 32'd5})
            $display("FAIL hold_next: addr=%h data=%h strb=%h bytes=%0d required 80000004 55 1 5",
                     a, d, s, bytes_loaded_o);
        else n_pass++;
    endtask

    task automatic test_max();
        logic [31:0] a, d;
        logic [3:0]  s;
        do_reset();
        pulse_start();
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        wait_write(a, d, s);
        n_total++;
        if ({m_mem_data_wr_o, m_mem_wr_o} !== {32'h0403_0201, 4'hF})
            $display("FAIL max_write: data=%h strb=%h required 04030201 f",
                     m_mem_data_wr_o, m_mem_wr_o);
        else n_pass++;
        mem_respond(1'b1, 1'b0);
        send_byte(8'h05, 1'b0);
        n_total++;
        if ({m_error_o, m_core_rst_o, m_done_o, m_byte_ready_o, m_mem_wr_o, m_bytes_loaded_o}
            !== {4'b1100, 4'h0, 32'd4})
            $display("FAIL max_error: err/rst/done/ready=%b strb=%h bytes=%0d required 1100 0 4",
                     {m_error_o, m_core_rst_o, m_done_o, m_byte_ready_o}, m_mem_wr_o,
                     m_bytes_loaded_o);
        else n_pass++;
        pulse_start();
        n_total++;
        if ({m_error_o, m_byte_ready_o, m_busy_o, m_bytes_loaded_o} !== {3'b011, 32'd0})
            $display("FAIL max_recover: err/ready/busy=%b bytes=%0d required 011 0",
                     {m_error_o, m_byte_ready_o, m_busy_o}, m_bytes_loaded_o);
        else n_pass++;
    endtask

    task automatic test_mem_error();
        logic [31:0] a, d;
        logic [3:0]  s;
        do_reset();
        pulse_start();
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        wait_write(a, d, s);
        mem_respond(1'b0, 1'b1);
        n_total++;
        if ({error_o, done_o, core_rst_o, busy_o, byte_ready_o} !== 5'b10100)
            $display("FAIL mem_error: err/done/rst/busy/ready=%b required 10100",
                     {error_o, done_o, core_rst_o, busy_o, byte_ready_o});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, d;
        logic [3:0]  s;
        do_reset();
        pulse_start();
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        wait_write(a, d, s);
        mem_respond(1'b1, 1'b0);
        for (int i = 5; i <= 8; i++) send_byte(8'(i), 1'b0);
        wait_write(a, d, s);
        mem_accept = 1'b1;
        tick();
        mem_accept = 1'b0;
        n_total++;
        if ({busy_o, mem_wr_o, mem_addr_o} !== {1'b1, 4'h0, 32'h8000_0004})
            $display("FAIL wait_ack_state: busy=%0b strb=%h addr=%h required 1 0 80000004",
                     busy_o, mem_wr_o, mem_addr_o);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({byte_ready_o, mem_wr_o, core_rst_o, busy_o, done_o, error_o} !== 9'b0_0000_1000)
            $display("FAIL midrst_ctrl: got %b required 000001000",
                     {byte_ready_o, mem_wr_o, core_rst_o, busy_o, done_o, error_o});
        else n_pass++;
        n_total++;
        if ({mem_addr_o, mem_data_wr_o, bytes_loaded_o, checksum_o} !== {32'h8000_0000, 96'h0})
            $display("FAIL midrst_data: addr=%h data=%h bytes=%0d sum=%h required 80000000 0 0 0",
                     mem_addr_o, mem_data_wr_o, bytes_loaded_o, checksum_o);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_checksum();
        logic [31:0] a, d;
        logic [3:0]  s;
        do_reset();
        pulse_start();
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        wait_write(a, d, s);
        mem_respond(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hFF, i == 3);
        wait_write(a, d, s);
        n_total++;
        if (d !== 32'hFFFF_FFFF) $display("FAIL cks_w1: data=%h required ffffffff", d);
        else n_pass++;
        mem_respond(1'b0, 1'b0);
        wait_done();
        n_total++;
        if ({done_o, checksum_o} !== {1'b1, 32'h0})
            $display("FAIL cks_sum: done=%0b sum=%h required 1 00000000", done_o, checksum_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tail();
        test_hold();
        test_max();
        test_mem_error();
        test_reset_mid();
        test_checksum();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
